// File: rtl/wr_buf_pkg.sv
// Shared types and write-type encodings for the dcache posted-write buffer.
package wr_buf_pkg;

   localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
   localparam logic [2:0] WR_TYPE_HALF = 3'b001;
   localparam logic [2:0] WR_TYPE_WORD = 3'b010;
   localparam logic [2:0] WR_TYPE_LINE = 3'b100;

   typedef struct packed {
      logic [2:0]   wrType;
      logic [31:0]  addr;
      logic [3:0]   wstrb;
      logic [127:0] data;
   } wr_buf_entry_t;

endpackage

// File: rtl/wr_buf_match.sv
// Line-granularity address match over the valid buffer entries.
module wr_buf_match #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0] i_valid,
   input  logic [27:0]      i_lineAddr [DEPTH],
   input  logic [27:0]      i_chkLine,
   output logic             o_hit
);

   always_comb begin
      o_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_valid[i] && (i_lineAddr[i] == i_chkLine)) begin
            o_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dcache_wr_buffer.sv
// Posted-write FIFO between dcache and the AXI bridge write port.
// Optional word-write merging into the tail entry with `WR_BUF_MERGE_EN.
module dcache_wr_buffer
   import wr_buf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_wr_req,
   input  logic [2:0]   in_wr_type,
   input  logic [31:0]  in_wr_addr,
   input  logic [3:0]   in_wr_wstrb,
   input  logic [127:0] in_wr_data,
   output logic         in_wr_rdy,
   output logic         data_wr_req,
   output logic [2:0]   data_wr_type,
   output logic [31:0]  data_wr_addr,
   output logic [3:0]   data_wr_wstrb,
   output logic [127:0] data_wr_data,
   input  logic         data_wr_rdy,
   input  logic         bridge_wr_empty,
   input  logic [31:0]  chk_addr,
   output logic         chk_hit,
   output logic         buf_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PW-1:0]   r_rdPtr;
   logic [PW-1:0]   r_wrPtr;
   logic [PW:0]     r_count;
   logic [DEPTH-1:0] r_valid;
   wr_buf_entry_t   r_mem [DEPTH];

   logic            w_write;
   logic            w_push;
   logic            w_pop;
   logic            w_merge;
   wr_buf_entry_t   w_inEntry;
   wr_buf_entry_t   w_head;
   logic [27:0]     w_lineAddr [DEPTH];
   logic            w_unusedChkBits;

   assign in_wr_rdy   = (r_count != FULL);
   assign data_wr_req = (r_count != '0);
   assign buf_empty   = (r_count == '0) && bridge_wr_empty;
   assign w_write     = in_wr_req && in_wr_rdy;
   assign w_pop       = data_wr_req && data_wr_rdy;
   assign w_inEntry   = '{wrType: in_wr_type, addr: in_wr_addr, wstrb: in_wr_wstrb, data: in_wr_data};

   assign w_head        = r_mem[r_rdPtr];
   assign data_wr_type  = w_head.wrType;
   assign data_wr_addr  = w_head.addr;
   assign data_wr_wstrb = w_head.wstrb;
   assign data_wr_data  = w_head.data;

`ifdef WR_BUF_MERGE_EN
   logic [PW-1:0]  w_tailPtr;
   wr_buf_entry_t  w_tail;
   wr_buf_entry_t  w_mergedEntry;

   assign w_tailPtr = r_wrPtr - 1'b1;
   assign w_tail    = r_mem[w_tailPtr];

   // A lone entry that is leaving this cycle must not absorb the new write
   assign w_merge = w_write && (in_wr_type == WR_TYPE_WORD) && (r_count != '0)
                    && (w_tail.wrType == WR_TYPE_WORD)
                    && (w_tail.addr[31:2] == in_wr_addr[31:2])
                    && !(w_pop && (r_count == (PW+1)'(1)));

   always_comb begin
      w_mergedEntry       = w_tail;
      w_mergedEntry.wstrb = w_tail.wstrb | in_wr_wstrb;
      for (int b = 0; b < 4; b++) begin
         if (in_wr_wstrb[b]) begin
            w_mergedEntry.data[8*b +: 8] = in_wr_data[8*b +: 8];
         end
      end
   end
`else
   assign w_merge = 1'b0;
`endif

   assign w_push = w_write && !w_merge;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr          <= r_wrPtr + 1'b1;
            r_valid[r_wrPtr] <= 1'b1;
         end
         if (w_pop) begin
            r_rdPtr          <= r_rdPtr + 1'b1;
            r_valid[r_rdPtr] <= 1'b0;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; r_valid and r_count qualify it
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= w_inEntry;
      end
`ifdef WR_BUF_MERGE_EN
      else if (w_merge) begin
         r_mem[w_tailPtr] <= w_mergedEntry;
      end
`endif
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_lineAddr[i] = r_mem[i].addr[31:4];
      end
   end

   assign w_unusedChkBits = ^chk_addr[3:0];

   wr_buf_match #(.DEPTH(DEPTH)) u_match (
      .i_valid    (r_valid),
      .i_lineAddr (w_lineAddr),
      .i_chkLine  (chk_addr[31:4]),
      .o_hit      (chk_hit)
   );

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Randomized self-checking bench for dcache_wr_buffer against a queue-based model.
// Merge expectations follow `WR_BUF_MERGE_EN when defined.
module tb_dcache_wr_buffer;
   import wr_buf_pkg::*;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         resetn;
   logic         in_wr_req;
   logic [2:0]   in_wr_type;
   logic [31:0]  in_wr_addr;
   logic [3:0]   in_wr_wstrb;
   logic [127:0] in_wr_data;
   logic         in_wr_rdy;
   logic         data_wr_req;
   logic [2:0]   data_wr_type;
   logic [31:0]  data_wr_addr;
   logic [3:0]   data_wr_wstrb;
   logic [127:0] data_wr_data;
   logic         data_wr_rdy;
   logic         bridge_wr_empty;
   logic [31:0]  chk_addr;
   logic         chk_hit;
   logic         buf_empty;

   wr_buf_entry_t modelQ [$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dcache_wr_buffer #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .in_wr_req       (in_wr_req),
      .in_wr_type      (in_wr_type),
      .in_wr_addr      (in_wr_addr),
      .in_wr_wstrb     (in_wr_wstrb),
      .in_wr_data      (in_wr_data),
      .in_wr_rdy       (in_wr_rdy),
      .data_wr_req     (data_wr_req),
      .data_wr_type    (data_wr_type),
      .data_wr_addr    (data_wr_addr),
      .data_wr_wstrb   (data_wr_wstrb),
      .data_wr_data    (data_wr_data),
      .data_wr_rdy     (data_wr_rdy),
      .bridge_wr_empty (bridge_wr_empty),
      .chk_addr        (chk_addr),
      .chk_hit         (chk_hit),
      .buf_empty       (buf_empty)
   );

   // One comparison: counts it and reports a mismatch
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic modelHit(input logic [31:0] a);
      logic hit = 1'b0;
      foreach (modelQ[i]) begin
         if (modelQ[i].addr[31:4] == a[31:4]) hit = 1'b1;
      end
      return hit;
   endfunction

   // Drive one cycle of inputs, compare outputs with the model, then advance the model across the edge
   task automatic applyStimulus(input logic req, input logic [2:0] typ, input logic [31:0] addr,
                                input logic [3:0] strb, input logic [127:0] data,
                                input logic rdy, input logic bEmpty, input logic [31:0] chk);
      int  sz;
      logic popNow, pushNow, mergeNow;
      wr_buf_entry_t t;
      @(negedge clk);
      in_wr_req = req; in_wr_type = typ; in_wr_addr = addr; in_wr_wstrb = strb; in_wr_data = data;
      data_wr_rdy = rdy; bridge_wr_empty = bEmpty; chk_addr = chk;
      #1;
      sz = modelQ.size();
      checkOutput("in_wr_rdy", in_wr_rdy, sz != DEPTH);
      checkOutput("data_wr_req", data_wr_req, sz != 0);
      if (sz != 0) begin
         checkOutput("head_type", data_wr_type, modelQ[0].wrType);
         checkOutput("head_addr", data_wr_addr, modelQ[0].addr);
         checkOutput("head_wstrb", data_wr_wstrb, modelQ[0].wstrb);
         checkOutput("head_data", data_wr_data, modelQ[0].data);
      end
      checkOutput("chk_hit", chk_hit, modelHit(chk));
      checkOutput("buf_empty", buf_empty, (sz == 0) && bEmpty);
      popNow   = (sz != 0) && rdy;
      pushNow  = req && (sz != DEPTH);
      mergeNow = 1'b0;
`ifdef WR_BUF_MERGE_EN
      if (pushNow && typ == WR_TYPE_WORD && sz != 0 && !(popNow && sz == 1)) begin
         t = modelQ[sz-1];
         if (t.wrType == WR_TYPE_WORD && t.addr[31:2] == addr[31:2]) begin
            mergeNow = 1'b1;
            for (int b = 0; b < 4; b++) if (strb[b]) t.data[8*b +: 8] = data[8*b +: 8];
            t.wstrb = t.wstrb | strb;
            modelQ[sz-1] = t;
         end
      end
`endif
      if (popNow) void'(modelQ.pop_front());
      if (pushNow && !mergeNow) begin
         t = '{wrType: typ, addr: addr, wstrb: strb, data: data};
         modelQ.push_back(t);
      end
      @(posedge clk);
   endtask

   task automatic doReset(input logic bEmpty, input logic [31:0] chk);
      @(negedge clk);
      resetn = 1'b0; in_wr_req = 1'b0; data_wr_rdy = 1'b0;
      bridge_wr_empty = bEmpty; chk_addr = chk;
      @(posedge clk);
      modelQ.delete();
      #1;
      checkOutput("rst_data_wr_req", data_wr_req, 1'b0);
      checkOutput("rst_in_wr_rdy", in_wr_rdy, 1'b1);
      checkOutput("rst_chk_hit", chk_hit, 1'b0);
      checkOutput("rst_buf_empty", buf_empty, bEmpty);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      logic [2:0] typePool [4];
      typePool = '{WR_TYPE_BYTE, WR_TYPE_HALF, WR_TYPE_WORD, WR_TYPE_LINE};
      resetn = 1'b0; in_wr_req = 1'b0; in_wr_type = '0; in_wr_addr = '0; in_wr_wstrb = '0;
      in_wr_data = '0; data_wr_rdy = 1'b0; bridge_wr_empty = 1'b1; chk_addr = '0;

      doReset(1'b0, 32'h0);

      // Single line write passes straight through
      applyStimulus(1'b1, WR_TYPE_LINE, 32'h1C00_0040, 4'h0,
                    128'h0007_0006_0005_0004_0003_0002_0001_0000, 1'b1, 1'b1, 32'h0);
      #1;
      checkOutput("line_req", data_wr_req, 1'b1);
      checkOutput("line_addr", data_wr_addr, 32'h1C00_0040);
      checkOutput("line_data", data_wr_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      applyStimulus(1'b0, WR_TYPE_BYTE, 32'h0, 4'h0, 128'h0, 1'b1, 1'b1, 32'h0);
      #1;
      checkOutput("line_drained", data_wr_req, 1'b0);

      // Fill while the bridge is busy, then drain
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, WR_TYPE_WORD, 32'h0000_0200 + 32'(i*16), 4'hF, 128'(i+1), 1'b0, 1'b0, 32'h0);
      #1;
      checkOutput("full_rdy", in_wr_rdy, 1'b0);
      applyStimulus(1'b1, WR_TYPE_WORD, 32'h0000_0300, 4'hF, 128'h55, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, WR_TYPE_BYTE, 32'h0, 4'h0, 128'h0, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("rdy_after_pop", in_wr_rdy, 1'b1);
      checkOutput("second_head", data_wr_addr, 32'h0000_0210);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, WR_TYPE_BYTE, 32'h0, 4'h0, 128'h0, 1'b1, 1'(i), 32'h0);

      // Interleaved push/pop so pointers wrap
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, WR_TYPE_LINE, 32'h0000_4000 + 32'(i*16), 4'h0, 128'(i*7), 1'(i%2), 1'b0, 32'h4020);
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b0, WR_TYPE_BYTE, 32'h0, 4'h0, 128'h0, 1'b1, 1'(i%2), 32'h4050);

      // Line-granularity address check
      applyStimulus(1'b1, WR_TYPE_WORD, 32'h8000_1230, 4'hF, 128'h1234, 1'b0, 1'b1, 32'h0);
      chk_addr = 32'h8000_123C;
      #1 checkOutput("chk_same_line", chk_hit, 1'b1);
      chk_addr = 32'h8000_1240;
      #1 checkOutput("chk_next_line", chk_hit, 1'b0);
      applyStimulus(1'b0, WR_TYPE_BYTE, 32'h0, 4'h0, 128'h0, 1'b1, 1'b1, 32'h8000_1238);
      applyStimulus(1'b0, WR_TYPE_BYTE, 32'h0, 4'h0, 128'h0, 1'b1, 1'b1, 32'h8000_1238);

      // Two word writes to the same address while blocked
      applyStimulus(1'b1, WR_TYPE_WORD, 32'h0000_0100, 4'b0001, 128'hAA, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b1, WR_TYPE_WORD, 32'h0000_0100, 4'b0100, 128'hBB0000, 1'b0, 1'b1, 32'h0);
      #1;
`ifdef WR_BUF_MERGE_EN
      checkOutput("merge_wstrb", data_wr_wstrb, 4'b0101);
      checkOutput("merge_data", data_wr_data[31:0], 32'h00BB_00AA);
`else
      checkOutput("nomerge_wstrb", data_wr_wstrb, 4'b0001);
      checkOutput("nomerge_data", data_wr_data[31:0], 32'h0000_00AA);
`endif
      applyStimulus(1'b0, WR_TYPE_BYTE, 32'h0, 4'h0, 128'h0, 1'b1, 1'b1, 32'h100);
      applyStimulus(1'b0, WR_TYPE_BYTE, 32'h0, 4'h0, 128'h0, 1'b1, 1'b1, 32'h100);

      // Reset discards queued entries
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, WR_TYPE_LINE, 32'h0000_3000 + 32'(i*16), 4'h0, 128'(i), 1'b0, 1'b0, 32'h0);
      doReset(1'b1, 32'h0000_3000);

      // Randomized traffic on a small address pool so hits and merges occur
      for (int n = 0; n < 2000; n++) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       typePool[$urandom_range(0, 3)],
                       32'h8000_1200 + 32'($urandom_range(0, 15) << 2),
                       4'($urandom),
                       {$urandom, $urandom, $urandom, $urandom},
                       ($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? $urandom : 32'h8000_1200 + 32'($urandom_range(0, 15) << 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
